// File: rtl/version_pkg.sv
// Build identification constants for the loaded bitstream.
// Regenerated by the build flow; values are BCD-style so they read naturally in hex.
package version_pkg;

  localparam logic [7:0]  MAJOR  = 8'h00;
  localparam logic [7:0]  MINOR  = 8'h00;
  localparam logic [7:0]  PATCH  = 8'h00;
  localparam logic [7:0]  BUILD  = 8'h44;
  localparam logic [15:0] YEAR   = 16'h2025;
  localparam logic [7:0]  MONTH  = 8'h11;
  localparam logic [7:0]  DAY    = 8'h11;
  localparam logic [7:0]  HOUR   = 8'h09;
  localparam logic [7:0]  MINUTE = 8'h23;
  localparam logic [7:0]  SECOND = 8'h21;

endpackage

// File: rtl/version_reporter_pkg.sv
// Shared types and frame constants for version_reporter.
// VERSION_REPORTER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package version_reporter_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [3:0] index_t;

  localparam logic [7:0] C_PAYLOAD_LEN = 8'd11;

`ifdef VERSION_REPORTER_CHECKSUM_EN
  localparam int C_FRAME_LEN = 14;
`else
  localparam int C_FRAME_LEN = 13;
`endif

endpackage

// File: rtl/version_frame_rom.sv
// Combinational frame-byte lookup over the build constants.
// With VERSION_REPORTER_CHECKSUM_EN, index 13 returns the constant XOR of bytes 1..12.
module version_frame_rom
  import version_reporter_pkg::*;
  import version_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'h56
) (
  input  index_t     index,
  output logic [7:0] data
);

`ifdef VERSION_REPORTER_CHECKSUM_EN
  // Folded at elaboration, so no XOR tree is built in fabric.
  localparam logic [7:0] C_CHECKSUM = C_PAYLOAD_LEN ^ MAJOR ^ MINOR ^ PATCH ^ BUILD ^
                                      YEAR[15:8] ^ YEAR[7:0] ^ MONTH ^ DAY ^
                                      HOUR ^ MINUTE ^ SECOND;
`endif

  always_comb begin
    data = 8'h00;
    case (index)
      4'd0:  data = SYNC_BYTE;
      4'd1:  data = C_PAYLOAD_LEN;
      4'd2:  data = MAJOR;
      4'd3:  data = MINOR;
      4'd4:  data = PATCH;
      4'd5:  data = BUILD;
      4'd6:  data = YEAR[15:8];
      4'd7:  data = YEAR[7:0];
      4'd8:  data = MONTH;
      4'd9:  data = DAY;
      4'd10: data = HOUR;
      4'd11: data = MINUTE;
      4'd12: data = SECOND;
`ifdef VERSION_REPORTER_CHECKSUM_EN
      4'd13: data = C_CHECKSUM;
`endif
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/version_reporter.sv
// Streams a framed version/build-date packet on request or periodically.
// Frame length follows VERSION_REPORTER_CHECKSUM_EN (13 bytes, or 14 with checksum).
module version_reporter
  import version_reporter_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'h56,
  parameter int         AUTO_PERIOD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast
);

  localparam index_t C_LAST = index_t'(C_FRAME_LEN - 1);

  state_t     state;
  index_t     index;
  index_t     next_index;
  index_t     rom_index;
  logic [7:0] rom_data;
  logic       pending;
  logic       wrap;

  // The ROM is addressed by the byte to be presented after the next edge.
  assign next_index = index_t'(index + 4'd1);
  assign rom_index  = (state == SEND) ? next_index : '0;

  version_frame_rom #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_rom (
    .index (rom_index),
    .data  (rom_data)
  );

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      localparam int CW = $clog2(AUTO_PERIOD + 1);
      logic [CW-1:0] count;

      assign wrap = (count == CW'(AUTO_PERIOD - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (wrap) begin
          count <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end
    end else begin : g_no_auto
      assign wrap = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      m_tdata    <= 8'h00;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // A wrap coinciding with req or pending is absorbed into this one frame.
          if (pending || req || wrap) begin
            state    <= SEND;
            index    <= '0;
            pending  <= 1'b0;
            busy     <= 1'b1;
            m_tvalid <= 1'b1;
            m_tdata  <= rom_data;
            m_tlast  <= 1'b0;
          end
        end
        SEND: begin
          if (req || wrap) begin
            pending <= 1'b1;
          end
          if (m_tvalid && m_tready) begin
            if (index == C_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              m_tvalid   <= 1'b0;
              m_tlast    <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              index   <= next_index;
              m_tdata <= rom_data;
              m_tlast <= (next_index == C_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
// Self-checking bench for version_reporter: directed frames, backpressure, reset, auto-send.
// Expected bytes follow VERSION_REPORTER_CHECKSUM_EN when the bench is built with it.
module tb_version_reporter;

`ifdef VERSION_REPORTER_CHECKSUM_EN
  localparam int LEN = 14;
`else
  localparam int LEN = 13;
`endif

  logic [7:0] exp_bytes [0:13] = '{8'h56, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h44, 8'h20,
                                   8'h25, 8'h11, 8'h11, 8'h09, 8'h23, 8'h21, 8'h41};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: request-driven only
  logic       rst, req, tready;
  logic       busy0, done0, tvalid0, tlast0;
  logic [7:0] tdata0;

  // dut1: auto-send every 50 cycles, always ready
  logic       rst1, req1;
  logic       tready1;
  logic       busy1, done1, tvalid1, tlast1;
  logic [7:0] tdata1;

  int n_cmp = 0;
  int n_bad = 0;

  version_reporter #(.SYNC_BYTE(8'h56), .AUTO_PERIOD(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy0),
    .frame_done (done0),
    .m_tdata    (tdata0),
    .m_tvalid   (tvalid0),
    .m_tready   (tready),
    .m_tlast    (tlast0)
  );

  version_reporter #(.SYNC_BYTE(8'h56), .AUTO_PERIOD(50)) dut1 (
    .clk        (clk),
    .rst        (rst1),
    .req        (req1),
    .busy       (busy1),
    .frame_done (done1),
    .m_tdata    (tdata1),
    .m_tvalid   (tvalid1),
    .m_tready   (tready1),
    .m_tlast    (tlast1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream monitor for dut0: byte order, tlast placement, stall stability, no mid-frame drop.
  int beat    = 0;
  int frames0 = 0;
  always @(negedge clk) begin
    if (rst) begin
      beat = 0;
    end else begin
      if (beat != 0) check_val("valid_hold", tvalid0, 1);
      if (tvalid0) begin
        check_val($sformatf("byte%0d", beat), tdata0, exp_bytes[beat]);
        check_val($sformatf("tlast%0d", beat), tlast0, (beat == LEN - 1));
        check_val("busy_in_frame", busy0, 1);
        if (tready) beat = (beat == LEN - 1) ? 0 : beat + 1;
      end
      if (done0) frames0++;
    end
  end

  // Frame-start log for dut1, timestamped in cycles since reset release.
  int   cyc1 = 0;
  int   starts1 [$];
  logic prev_v1 = 1'b0;
  always @(posedge clk or posedge rst1) begin
    if (rst1) cyc1 <= 0;
    else      cyc1 <= cyc1 + 1;
  end
  always @(negedge clk) begin
    if (!rst1 && tvalid1 && !prev_v1) starts1.push_back(cyc1);
    prev_v1 = tvalid1;
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fb;
    int gap_i;
    bit seen_done;

    rst = 1'b1; rst1 = 1'b1; req = 1'b0; req1 = 1'b0; tready = 1'b1; tready1 = 1'b1;
    repeat (3) tick();
    check_val("rst_busy", busy0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_tvalid", tvalid0, 0);
    check_val("rst_tlast", tlast0, 0);
    check_val("rst_tdata", tdata0, 0);
    check_val("rst_tvalid1", tvalid1, 0);
    rst = 1'b0; rst1 = 1'b0;

    // Auto-send: starts at 50,100,150,200; req on the 250 wrap must give one frame.
    while (cyc1 < 249) tick();
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    while (cyc1 < 300) tick();
    check_val("auto_frame_count", starts1.size(), 5);
    for (int i = 0; i < 5; i++)
      check_val($sformatf("auto_start%0d", i), (i < starts1.size()) ? starts1[i] : -1, 50 * (i + 1));

    // Single request, always ready.
    tready = 1'b1;
    fb = frames0;
    req = 1'b1;
    tick();
    req = 1'b0;
    check_val("latency_tvalid", tvalid0, 1);
    check_val("latency_sync", tdata0, 8'h56);
    check_val("busy_start", busy0, 1);
    repeat (LEN - 1) tick();
    check_val("last_byte", tdata0, exp_bytes[LEN - 1]);
    check_val("last_tlast", tlast0, 1);
    tick();
    check_val("done_pulse", done0, 1);
    check_val("done_tvalid", tvalid0, 0);
    check_val("done_busy", busy0, 0);
    tick();
    check_val("done_single", done0, 0);
    check_val("single_frames", frames0 - fb, 1);

    // Toggling ready with reqs mid-frame: one frame plus exactly one coalesced frame.
    fb = frames0;
    seen_done = 1'b0;
    gap_i = -10;
    for (int i = 0; i < 120; i++) begin
      tready = (i % 2 == 0);
      req = (i == 0 || i == 4 || i == 6 || i == 9);
      tick();
      if (done0 && !seen_done) begin
        seen_done = 1'b1;
        gap_i = i;
        check_val("gap_tvalid", tvalid0, 0);
      end
      if (i == gap_i + 1) check_val("gap_restart", tvalid0, 1);
    end
    req = 1'b0;
    tready = 1'b1;
    check_val("coalesce_frames", frames0 - fb, 2);
    check_val("coalesce_idle", busy0, 0);

    // Reset in the middle of a frame.
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    check_val("pre_rst_byte5", tdata0, exp_bytes[5]);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_tvalid", tvalid0, 0);
    check_val("async_busy", busy0, 0);
    check_val("async_tdata", tdata0, 0);
    fb = frames0;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check_val("rst_no_done", frames0 - fb, 0);
    check_val("rst_stays_idle", tvalid0, 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    check_val("restart_sync", tdata0, 8'h56);
    check_val("restart_tvalid", tvalid0, 1);
    for (int i = 0; i < 40 && busy0; i++) tick();
    check_val("restart_complete", busy0, 0);

    // Long stall: held sync byte, no progress.
    tready = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (1000) tick();
    check_val("stall_tvalid", tvalid0, 1);
    check_val("stall_tdata", tdata0, 8'h56);
    check_val("stall_busy", busy0, 1);
    check_val("stall_tlast", tlast0, 0);
    fb = frames0;
    tready = 1'b1;
    for (int i = 0; i < 40 && !done0; i++) tick();
    check_val("stall_drain_done", done0, 1);
    tick();
    check_val("stall_frames", frames0 - fb, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/version_reporter.md
Name: version_reporter

Overview:
- Reads the build version/date constants from version_pkg.
- On request, or periodically, streams them out as a framed byte packet on an AXI-Stream-style byte master.
- Gives host/debug logic (UART bridge, JTAG mailbox) a readback of which bitstream is loaded.
- Sits between the version package and the board's debug byte link.

Parameters:
- SYNC_BYTE, 8'h56, first byte of every frame ('V').
- AUTO_PERIOD, 0, cycles between automatic frames; 0 disables auto-send.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  one-cycle request for a frame.
- busy  out  1  high while a frame is in flight (state SEND).
- frame_done  out  1  one-cycle pulse on acceptance of the last beat.
- m_tdata  out  8  frame byte.
- m_tvalid  out  1  byte valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  marks final frame byte.

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: busy=0, frame_done=0, m_tvalid=0, m_tlast=0, m_tdata=0; pending flag=0; index=0; auto counter=0.
- Assertion of rst drops m_tvalid combinationally-fast (async). A frame cut by reset is abandoned and never resumed.
- Frame layout, index 0..FRAME_LEN-1:
  - 0: SYNC_BYTE
  - 1: payload length 8'd11
  - 2..12: MAJOR, MINOR, PATCH, BUILD, YEAR[15:8], YEAR[7:0], MONTH, DAY, HOUR, MINUTE, SECOND
  - optional 13: checksum (see Optional Feature)
- FRAME_LEN is 13 without the feature and 14 with it.
- States:
  - IDLE: m_tvalid=0. If pending or req, go to SEND with index=0 and clear pending.
  - SEND: m_tvalid=1, m_tdata=byte[index], m_tlast=(index==FRAME_LEN-1).
    - On m_tvalid&&m_tready: index+1.
    - On the last beat: pulse frame_done next cycle, return to IDLE.
- Latency: req in IDLE gives m_tvalid=1 on the following cycle (1-cycle latency).
- Stream rules:
  - m_tdata and m_tlast are registered and held stable while m_tvalid&&!m_tready.
  - m_tvalid never deasserts mid-frame.
  - Back-to-back frames: pending serviced from IDLE, leaving a one-cycle valid gap between frames.
- Request handling:
  - req during SEND sets pending (one-deep). Further reqs coalesce into it.
  - req on the last-beat cycle also sets pending.
- Auto-send (AUTO_PERIOD>0):
  - Free-running counter 0..AUTO_PERIOD-1, sized $clog2(AUTO_PERIOD+1); it wraps and sets pending on wrap.
  - Wrap coinciding with req yields one frame only.
- Backpressure: m_tready held 0 indefinitely stalls without loss. The auto counter keeps running; pending stays one-deep.

Optional Feature:
- Macro: VERSION_REPORTER_CHECKSUM_EN.
- Defined: FRAME_LEN=14; byte 13 = XOR of bytes 1..12, m_tlast on byte 13.
- Undefined: FRAME_LEN=13, m_tlast on SECOND (byte 12), no checksum logic.

Decomposition:
- Package version_reporter_pkg holds:
  - state enum {IDLE, SEND}
  - C_PAYLOAD_LEN=8'd11
  - C_FRAME_LEN (macro-dependent)
  - index typedef logic [3:0]
- Sub-module version_frame_rom: combinational index→byte mux over the version_pkg constants, including the checksum computed as a constant.
- Top handles FSM, pending, auto counter and output registers.

Test Plan:
- Single req, m_tready=1, no macro, version 0.0.0.68 / 2025-11-11 09:23:21 → bytes 56 0B 00 00 00 44 20 25 11 11 09 23 21, m_tlast on 13th, frame_done one cycle later, busy low after.
- Macro defined, same build → 14 bytes ending 0x41, m_tlast only on 0x41.
- m_tready toggling 1010…, 3 reqs pulsed mid-frame → first frame intact with data stable during stalls, then exactly one more frame after a 1-cycle gap.
- AUTO_PERIOD=50, no req, m_tready=1 for 200 cycles → 4 frames, starts spaced 50 cycles; req on a wrap cycle adds no extra frame.
- rst asserted at byte 5 with m_tvalid high → m_tvalid=0 immediately, no frame_done; next req restarts at SYNC_BYTE.
- m_tready=0 for 1000 cycles after req → m_tvalid=1 with m_tdata=0x56 held, busy=1 throughout, no index advance.
